// File: rtl/div_if.sv
// Handshake and result bundle for the 16/8 unsigned divider.
// The div_by_zero flag exists only when DIV_ZERO_FLAG_EN is defined.
interface div_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_by_zero;
`endif

`ifdef DIV_ZERO_FLAG_EN
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/div.sv
// Unsigned 16-bit by 8-bit restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_FLAG_EN -- a zero divisor short-cuts to
// DONE one cycle after acceptance and raises div_by_zero. Without it a zero
// divisor simply runs the 16 steps (yielding 16'hFFFF and dividend[7:0]).
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] dvd;       // dividend, shifted left as bits are consumed
  logic [7:0]  dvs;       // captured divisor
  logic [8:0]  prem;      // partial remainder
  logic [15:0] q_work;    // quotient under construction
  logic [4:0]  count;     // steps completed
`ifdef DIV_ZERO_FLAG_EN
  logic        zero_pend; // zero divisor accepted, result due next edge
`endif

  logic [8:0]  shifted;
  logic [8:0]  trial;
  logic        qbit;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {prem[7:0], dvd[15]};
    if (shifted >= {1'b0, dvs}) begin
      trial = shifted - {1'b0, dvs};
      qbit  = 1'b1;
    end else begin
      trial = shifted;
      qbit  = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dvd           <= 16'd0;
      dvs           <= 8'd0;
      prem          <= 9'd0;
      q_work        <= 16'd0;
      count         <= 5'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= 16'd0;
      bus.remainder <= 8'd0;
`ifdef DIV_ZERO_FLAG_EN
      zero_pend       <= 1'b0;
      bus.div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          if (zero_pend) begin
            // Zero divisor: fixed result pattern, no iterations.
            zero_pend       <= 1'b0;
            bus.quotient    <= 16'hFFFF;
            bus.remainder   <= dvd[7:0];
            bus.div_by_zero <= 1'b1;
            bus.done        <= 1'b1;
            state           <= DONE;
          end else
`endif
          if (bus.start) begin
            dvd    <= bus.dividend;
            dvs    <= bus.divisor;
            prem   <= 9'd0;
            q_work <= 16'd0;
            count  <= 5'd0;
`ifdef DIV_ZERO_FLAG_EN
            bus.div_by_zero <= 1'b0;
            if (bus.divisor == 8'd0) begin
              zero_pend <= 1'b1;
              state     <= IDLE;
            end else begin
              bus.busy <= 1'b1;
              state    <= RUN;
            end
`else
            bus.busy <= 1'b1;
            state    <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored while iterating.
          prem   <= trial;
          q_work <= {q_work[14:0], qbit};
          dvd    <= {dvd[14:0], 1'b0};
          count  <= count + 5'd1;
          if (count == 5'd15) begin
            bus.quotient  <= {q_work[14:0], qbit};
            bus.remainder <= trial[7:0];
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases, start-during-RUN,
// back-to-back, mid-run reset and a randomized sweep against a plain
// arithmetic reference model.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] last_q;
  logic [7:0]  last_r;

  always #5 clk = ~clk;

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
  endtask

  // Follow one operation from the cycle after acceptance to its done pulse.
  task automatic collect(input logic [15:0] a, input logic [7:0] b, input bit mid,
                         input bit chain, input logic [15:0] na, input logic [7:0] nb);
    int e = 0;
    int busy_cnt = 0;
    bit got_done = 1'b0;
    int elat;
    int ebusy;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ezero;
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = a[7:0];
    end else begin
      eq = a / {8'd0, b};
      er = 8'(a % {8'd0, b});
    end
`ifdef DIV_ZERO_FLAG_EN
    ezero = (b == 8'd0);
`else
    ezero = 1'b0;
`endif
    elat  = ezero ? 1 : 16;
    ebusy = ezero ? 0 : 16;
    while (!got_done && e <= 40) begin
      check_eq("busy_done_overlap", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        check_eq("q_held", {16'd0, bus.quotient}, {16'd0, last_q});
        check_eq("r_held", {24'd0, bus.remainder}, {24'd0, last_r});
        if (mid && e == 5) begin
          bus.start    = 1'b1;
          bus.dividend = 16'($urandom);
          bus.divisor  = 8'($urandom_range(1, 255));
        end else begin
          bus.start = 1'b0;
        end
        tick();
        e++;
      end
    end
    check_eq("done_seen", {31'd0, got_done}, 32'd1);
    check_eq("latency", e, elat);
    check_eq("busy_cycles", busy_cnt, ebusy);
    check_eq("quotient", {16'd0, bus.quotient}, {16'd0, eq});
    check_eq("remainder", {24'd0, bus.remainder}, {24'd0, er});
`ifdef DIV_ZERO_FLAG_EN
    check_eq("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, ezero});
`endif
    last_q = eq;
    last_r = er;
    if (chain) begin
      issue(na, nb);
      check_eq("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end else begin
      tick();
      check_eq("done_one_cycle", {31'd0, bus.done}, 32'd0);
      check_eq("idle_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("q_after", {16'd0, bus.quotient}, {16'd0, eq});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_q"}, {16'd0, bus.quotient}, 32'd0);
    check_eq({tag, "_r"}, {24'd0, bus.remainder}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check_eq({tag, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 8'd0;
    last_q       = 16'd0;
    last_r       = 8'd0;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Directed values
    issue(16'd1000, 8'd7);      collect(16'd1000, 8'd7, 1'b0, 1'b0, 16'd0, 8'd0);
    issue(16'hFFFF, 8'h01);     collect(16'hFFFF, 8'h01, 1'b0, 1'b0, 16'd0, 8'd0);
    issue(16'd5, 8'd10);        collect(16'd5, 8'd10, 1'b0, 1'b0, 16'd0, 8'd0);
    issue(16'h00FF, 8'hFF);     collect(16'h00FF, 8'hFF, 1'b0, 1'b0, 16'd0, 8'd0);
    issue(16'h1234, 8'h00);     collect(16'h1234, 8'h00, 1'b0, 1'b0, 16'd0, 8'd0);

    // start during RUN ignored, then back-to-back start in the DONE cycle
    issue(16'd40000, 8'd13);
    collect(16'd40000, 8'd13, 1'b1, 1'b1, 16'd777, 8'd3);
    collect(16'd777, 8'd3, 1'b0, 1'b0, 16'd0, 8'd0);

    // Reset in the middle of an operation
    issue(16'd12345, 8'd9);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("midrst");
    last_q = 16'd0;
    last_r = 8'd0;
    for (int i = 0; i < 20; i++) begin
      check_eq("no_done_after_rst", {31'd0, bus.done}, 32'd0);
      tick();
    end

    // Randomized sweep, divisor != 0
    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      issue(a, b);
      collect(a, b, 1'b0, 1'b0, 16'd0, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
